// File: rtl/uart_tx_sched.sv
// uart_tx_sched: round-robin scheduler sharing one 8N1 UART TX line among NUM_REQ byte requesters.
module uart_tx_sched #(
    parameter int NUM_REQ = 4,
    parameter int IDW     = 2
) (
    input  logic                   clk_50m,
    input  logic                   rst,
    input  logic                   txclk_en,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [8*NUM_REQ-1:0]   req_data,
    output logic [NUM_REQ-1:0]     req_ready,
    output logic                   tx,
    output logic                   busy,
    output logic [IDW-1:0]         grant_id
);
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
    state_t         state, state_next;
    logic [IDW-1:0] ptr, g, idx;
    logic [7:0]     shreg;
    logic [2:0]     bit_cnt;
    logic           found, accept;
    // Scan downward so the lowest offset from ptr wins.
    always_comb begin
        g = ptr;
        idx = '0;
        found = 1'b0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = IDW'((int'(ptr) + k) % NUM_REQ);
            if (req_valid[idx]) begin
                g = idx;
                found = 1'b1;
            end
        end
    end
    assign accept    = (state == IDLE) && found;
    assign req_ready = accept ? NUM_REQ'(1) << g : '0;
    assign busy      = state != IDLE;
    always_ff @(posedge clk_50m) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    state_next = accept ? START : IDLE;
            START:   state_next = txclk_en ? DATA : START;
            DATA:    state_next = (txclk_en && bit_cnt == 3'd7) ? STOP : DATA;
            default: state_next = txclk_en ? IDLE : STOP;
        endcase
    end
    always_ff @(posedge clk_50m) begin
        if (rst) begin
            tx       <= 1'b1;
            ptr      <= '0;
            grant_id <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    shreg    <= req_data[8*g +: 8];
                    grant_id <= g;
                    ptr      <= (int'(g) == NUM_REQ - 1) ? '0 : g + 1'b1;
                end
                START: if (txclk_en) begin
                    tx      <= 1'b0;
                    bit_cnt <= '0;
                end
                DATA: if (txclk_en) begin
                    tx      <= shreg[bit_cnt];
                    bit_cnt <= bit_cnt + 1'b1;
                end
                default: if (txclk_en) tx <= 1'b1;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_sched.sv
// tb_uart_tx_sched: randomized scenario bench for uart_tx_sched against a frame-level round-robin model.
module tb_uart_tx_sched;
    localparam int N = 4;
    logic           clk_50m = 1'b0;
    logic           rst = 1'b1;
    logic           txclk_en = 1'b0;
    logic [N-1:0]   req_valid = '0;
    logic [8*N-1:0] req_data = '0;
    logic [N-1:0]   req_ready;
    logic           tx, busy;
    logic [1:0]     grant_id;
    int checks = 0, failures = 0, tick_gap = 16, ready_bad = 0, mptr = 0;

    uart_tx_sched #(.NUM_REQ(N), .IDW(2)) dut (
        .clk_50m(clk_50m), .rst(rst), .txclk_en(txclk_en), .req_valid(req_valid),
        .req_data(req_data), .req_ready(req_ready), .tx(tx), .busy(busy), .grant_id(grant_id)
    );

    always #5 clk_50m = ~clk_50m;

    initial begin : tickgen
        int cnt;
        cnt = 0;
        forever begin
            @(posedge clk_50m);
            #1;
            if (cnt >= tick_gap - 1) begin
                txclk_en = 1'b1;
                cnt = 0;
            end else begin
                txclk_en = 1'b0;
                cnt++;
            end
        end
    end

    // ready must be one-hot or zero, only to valid requesters, and never while a frame is in flight
    initial begin : ready_mon
        forever begin
            @(negedge clk_50m);
            #2;
            if (!rst && (((req_ready & ~req_valid) != 0) || ($countones(req_ready) > 1) || (busy && req_ready != 0)))
                ready_bad++;
        end
    end

    function automatic int rr_pick(input logic [N-1:0] v, input int p);
        for (int k = 0; k < N; k++) if (v[(p + k) % N]) return (p + k) % N;
        return -1;
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        req_valid = '0;
        @(negedge clk_50m);
        @(negedge clk_50m);
        rst = 1'b0;
        mptr = 0;
    endtask

    task automatic wait_accept(output int g);
        int n, eg;
        n = 0;
        g = -1;
        #1;
        while ((req_valid & req_ready) == 0 && n < 400) begin
            @(negedge clk_50m);
            #1;
            n++;
        end
        checks++;
        if ((req_valid & req_ready) == 0) begin
            failures++;
            $display("FAIL accept_timeout: no accept within %0d cycles, req_valid=%b", n, req_valid);
            return;
        end
        eg = rr_pick(req_valid, mptr);
        for (int i = 0; i < N; i++) if (req_ready[i]) g = i;
        if (req_ready !== (N'(1) << eg)) begin
            failures++;
            $display("FAIL grant_ready: req_ready=%b expected=%b", req_ready, N'(1) << eg);
        end
        mptr = (eg + 1) % N;
        @(negedge clk_50m);
        checks++;
        if (grant_id !== 2'(eg)) begin
            failures++;
            $display("FAIL grant_id: got=%0d expected=%0d", grant_id, eg);
        end
    endtask

    task automatic run_frame(input logic [7:0] b, input int first, input int last, input string nm);
        logic [9:0] exp_bits;
        int n;
        exp_bits = {1'b1, b, 1'b0};
        for (int t = first; t <= last; t++) begin
            n = 0;
            while (!txclk_en && n < 100) begin
                @(negedge clk_50m);
                n++;
            end
            if (n >= 100) begin
                checks++;
                failures++;
                $display("FAIL %s tick_timeout at bit %0d", nm, t);
            end
            @(negedge clk_50m);
            checks++;
            if (tx !== exp_bits[t]) begin
                failures++;
                $display("FAIL %s tx bit %0d: got=%b expected=%b (byte %h)", nm, t, tx, exp_bits[t], b);
            end
            checks++;
            if (busy !== (t < 9)) begin
                failures++;
                $display("FAIL %s busy after tick %0d: got=%b expected=%b", nm, t, busy, t < 9);
            end
        end
    endtask

    task automatic test_reset();
        @(negedge clk_50m);
        @(negedge clk_50m);
        rst = 1'b0;
        @(negedge clk_50m);
        checks += 4;
        if (tx !== 1'b1) begin failures++; $display("FAIL reset_tx: got=%b expected=1", tx); end
        if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got=%b expected=0", busy); end
        if (grant_id !== 2'd0) begin failures++; $display("FAIL reset_grant_id: got=%0d expected=0", grant_id); end
        if (req_ready !== 4'b0000) begin failures++; $display("FAIL reset_ready_idle: got=%b expected=0000", req_ready); end
        req_valid = 4'b0100;
        #1;
        checks++;
        if (req_ready !== 4'b0100) begin failures++; $display("FAIL reset_ready_follow: got=%b expected=0100", req_ready); end
        req_valid = '0;
        @(negedge clk_50m);
    endtask

    task automatic test_single();
        int g;
        req_data[7:0] = 8'hA5;
        req_valid = 4'b0001;
        wait_accept(g);
        req_valid = '0;
        run_frame(8'hA5, 0, 9, "single");
    endtask

    task automatic test_fairness();
        int g;
        logic [7:0] b;
        do_reset();
        for (int i = 0; i < N; i++) req_data[8*i +: 8] = 8'($urandom);
        req_valid = '1;
        for (int f = 0; f < 5; f++) begin
            wait_accept(g);
            checks++;
            if (g !== f % N) begin failures++; $display("FAIL fair_order frame %0d: got=%0d expected=%0d", f, g, f % N); end
            if (g < 0) g = 0;
            b = req_data[8*g +: 8];
            req_data[8*g +: 8] = 8'($urandom);
            if (f == 4) req_valid = '0;
            run_frame(b, 0, 9, "fair");
            if (f < 4) begin
                #1;
                checks++;
                if ((req_valid & req_ready) == 0) begin
                    failures++;
                    $display("FAIL fair_back_to_back frame %0d: req_ready=%b expected nonzero", f, req_ready);
                end
            end
        end
    endtask

    task automatic test_skip();
        int g;
        logic [7:0] b0, b1, b2;
        do_reset();
        b0 = 8'($urandom); b1 = 8'($urandom); b2 = 8'($urandom);
        req_data = {8'h00, b2, b1, b0};
        req_valid = 4'b0010;
        wait_accept(g);
        req_valid = 4'b0101;
        run_frame(b1, 0, 9, "skip1");
        wait_accept(g);
        checks++;
        if (g !== 2) begin failures++; $display("FAIL skip_first: got=%0d expected=2", g); end
        req_valid[2] = 1'b0;
        run_frame(b2, 0, 9, "skip2");
        wait_accept(g);
        checks++;
        if (g !== 0) begin failures++; $display("FAIL skip_second: got=%0d expected=0", g); end
        req_valid[0] = 1'b0;
        run_frame(b0, 0, 9, "skip0");
        checks++;
        if (ready_bad !== 0) begin failures++; $display("FAIL ready_rule: violations=%0d expected=0", ready_bad); end
    endtask

    task automatic test_accept_tick();
        int g, n;
        logic [7:0] b;
        do_reset();
        b = 8'($urandom);
        req_data[7:0] = b;
        n = 0;
        while (!txclk_en && n < 64) begin
            @(negedge clk_50m);
            n++;
        end
        req_valid = 4'b0001;
        wait_accept(g);
        req_valid = '0;
        n = 0;
        while (tx !== 1'b0 && n < 40) begin
            @(negedge clk_50m);
            n++;
        end
        checks++;
        if (n != 16) begin failures++; $display("FAIL accept_tick_start_delay: got=%0d cycles expected=16", n); end
        run_frame(b, 1, 9, "acctick");
    endtask

    task automatic test_reset_mid();
        int g;
        logic [7:0] b, b0;
        do_reset();
        b = 8'($urandom) & 8'hF7;
        b0 = 8'($urandom);
        req_data[23:16] = b;
        req_valid = 4'b0100;
        wait_accept(g);
        req_valid = '0;
        run_frame(b, 0, 4, "mid");
        rst = 1'b1;
        @(negedge clk_50m);
        rst = 1'b0;
        mptr = 0;
        checks += 3;
        if (tx !== 1'b1) begin failures++; $display("FAIL mid_reset_tx: got=%b expected=1", tx); end
        if (busy !== 1'b0) begin failures++; $display("FAIL mid_reset_busy: got=%b expected=0", busy); end
        if (grant_id !== 2'd0) begin failures++; $display("FAIL mid_reset_grant_id: got=%0d expected=0", grant_id); end
        req_data[7:0] = b0;
        req_valid = 4'b1001;
        wait_accept(g);
        checks++;
        if (g !== 0) begin failures++; $display("FAIL mid_reset_next: got=%0d expected=0", g); end
        req_valid = '0;
        run_frame(b0, 0, 9, "postmid");
    endtask

    task automatic test_sparse();
        int g;
        tick_gap = 3;
        do_reset();
        req_data[31:24] = 8'hFF;
        req_valid = 4'b1000;
        wait_accept(g);
        req_data[31:24] = 8'h00;
        run_frame(8'hFF, 0, 9, "sparse_ff");
        #1;
        checks++;
        if (req_ready !== 4'b1000) begin failures++; $display("FAIL sparse_back_to_back: req_ready=%b expected=1000", req_ready); end
        wait_accept(g);
        req_valid = '0;
        run_frame(8'h00, 0, 9, "sparse_00");
    endtask

    initial begin
        test_reset();
        test_single();
        test_fairness();
        test_skip();
        test_accept_tick();
        test_reset_mid();
        test_sparse();
        checks++;
        if (ready_bad !== 0) begin failures++; $display("FAIL ready_rule_final: violations=%0d expected=0", ready_bad); end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/uart_tx_sched.md
# uart_tx_sched

Round-robin transmit scheduler that shares one UART TX line among NUM_REQ byte requesters. It sits downstream of the baud rate generator and consumes its txclk_en strobe. Each accepted byte goes out as one 8N1 frame (start, 8 data bits LSB first, stop), with every bit boundary aligned to txclk_en. Requesters see a valid/ready handshake; the line is never driven by more than one frame at a time.

## Interface
Parameters:
- NUM_REQ, 4: number of requesters; range 2..8.
- IDW, 2: width of grant_id; equals ceil(log2(NUM_REQ)).

Ports:
- clk_50m  input  1  system clock; all logic is on its rising edge.
- rst  input  1  reset; one clock; reset is synchronous and active-high.
- txclk_en  input  1  one-cycle baud tick from the baud rate generator.
- req_valid  input  NUM_REQ  bit i: requester i holds a byte.
- req_data  input  8*NUM_REQ  requester i byte in bits [8i+7:8i].
- req_ready  output  NUM_REQ  one-hot or zero; byte i is accepted in a cycle with req_valid[i] & req_ready[i].
- tx  output  1  serial line, idle high; registered.
- busy  output  1  high when state is not IDLE.
- grant_id  output  IDW  index of the most recently accepted requester; registered.

## Operation
- State machine: IDLE, START, DATA, STOP.
- IDLE
  - tx is held at 1.
  - The scheduler searches from pointer ptr upward, modulo NUM_REQ, for the first set req_valid bit.
  - req_ready is driven combinationally for that requester only. req_ready is 0 in every other state.
  - On accept: latch the byte into shreg, set grant_id to g, set ptr to (g+1) mod NUM_REQ, and go to START.
- START: on txclk_en, drive tx to 0, clear bit_cnt, and go to DATA.
- DATA: on each txclk_en, drive tx to shreg[bit_cnt] and increment bit_cnt (3 bits). After the tick that drives bit 7, go to STOP.
- STOP: on txclk_en, drive tx to 1 and go to IDLE.
- Stop bit length: the next START waits for a fresh tick, so the stop bit always lasts at least one full tick period.
- txclk_en is ignored in IDLE and in the accept cycle.
- Requesters hold valid and data stable until accepted. The block never reads req_data outside the accept cycle.
- Reset, including mid-frame:
  - state goes to IDLE and tx returns to 1 on the next cycle.
  - ptr, grant_id and bit_cnt are cleared to 0; busy is 0.
  - Any partial frame is abandoned and not retried.
- Reset values: tx=1, busy=0, grant_id=0, req_ready follows the IDLE rule from the first cycle after reset.

## Timing
- Accept in cycle c puts the block in START at c+1.
- tx falls in the cycle after the first txclk_en seen in START, at tick T0.
- Data bit k appears after tick T(k+1); the stop bit appears after tick T9.
- The block returns to IDLE after T9, so a new accept can occur at T9+1.
- That frame's start bit appears after T10 at the earliest, so back-to-back frames have a pitch of exactly 10 ticks.
- Minimum txclk_en spacing is 3 cycles. At 115200 baud from 50 MHz the spacing is 434 cycles.
- ptr is updated only on accept. A requester that drops valid is skipped with no penalty.

## Test plan
- Single byte: req 0 sends 0xA5 with a tick every 16 cycles.
  - tx sequence, sampled per tick, is 0,1,0,1,0,0,1,0,1,1.
  - busy is high for 10 ticks; grant_id=0.
- Fairness: all 4 requesters valid continuously.
  - Grants go 0,1,2,3,0.
  - Frames are back-to-back with the stop bit exactly one tick period long.
- Skip: after a grant to 1, only req 0 and req 2 are valid.
  - Grants go 2 then 0.
  - req_ready is never asserted to an idle requester.
- Tick in the accept cycle: txclk_en coincides with the accept.
  - That tick is ignored.
  - The start bit begins after the next tick, 16 cycles later.
- Reset mid-frame: assert rst after data bit 3.
  - tx=1 and busy=0 on the next cycle.
  - grant_id=0; the next accept starts from requester 0.
- Sparse ticks: tick spacing of 3 cycles with requester 3 sending 0xFF then 0x00.
  - Both frames are correct.
  - No tick is missed at the IDLE/START boundary.
